// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C slave bus-phase codes and widths
package i2c_pkg;

    localparam int STATE_W   = 3;
    localparam int BIT_CNT_W = 3;

    // Codes must match the decoder in i2c_slave_sdalogic.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_RW    = 3'd3,
        ST_ACK   = 3'd4,
        ST_MEM   = 3'd5,
        ST_DATA  = 3'd6
    } i2c_state_t;

    typedef enum logic [1:0] {
        ACK_ADDR = 2'd0,
        ACK_MEM  = 2'd1,
        ACK_DATA = 2'd2
    } ack_phase_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-flop pin synchronizer with rise/fall decode
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset high so an idle (pulled-up) bus produces no edge on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/i2c_slave_fsm.sv
// rtl/i2c_slave_fsm.sv - I2C slave bus-phase sequencer, bit and timeout counters
module i2c_slave_fsm
    import i2c_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCL,
    input  logic                 SDA,
    input  logic                 addr_match,
    output logic [STATE_W-1:0]   state,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 rw,
    output logic [1:0]           ack_phase,
    output logic                 scl_rise,
    output logic                 scl_fall,
    output logic                 start_det,
    output logic                 stop_det,
    output logic                 timeout,
    output logic                 busy
);

    logic scl_q, scl_r, scl_f;
    logic sda_q, sda_r, sda_f;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (SCL),
        .q     (scl_q),
        .rise  (scl_r),
        .fall  (scl_f)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (SDA),
        .q     (sda_q),
        .rise  (sda_r),
        .fall  (sda_f)
    );

    // SCL must have been high in both the current and previous sample.
    logic start_c, stop_c, tmo_c;
    assign start_c = sda_f & scl_q & ~scl_r;
    assign stop_c  = sda_r & scl_q & ~scl_r;

    i2c_state_t     state_q;
    ack_phase_t     ack_q;
    logic           full;
    logic [15:0]    tcnt;

    assign tmo_c = (TIMEOUT != 16'd0) && (state_q != ST_IDLE) &&
                   (tcnt == TIMEOUT - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ack_q     <= ACK_ADDR;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            full      <= 1'b0;
            tcnt      <= '0;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            scl_rise  <= scl_r;
            scl_fall  <= scl_f;
            start_det <= start_c;
            stop_det  <= stop_c;
            timeout   <= 1'b0;

            if (state_q == ST_IDLE || scl_r || scl_f)
                tcnt <= '0;
            else
                tcnt <= tcnt + 16'd1;

            if (stop_c) begin
                state_q <= ST_IDLE;
                bit_cnt <= '0;
                full    <= 1'b0;
            end else if (start_c) begin
                state_q <= ST_START;
                ack_q   <= ACK_ADDR;
                bit_cnt <= '0;
                rw      <= 1'b0;
                full    <= 1'b0;
            end else if (scl_r || scl_f) begin
                // full marks "field complete": one rise seen in RW/ACK, eight in MEM/DATA.
                case (state_q)
                    ST_START: begin
                        if (scl_f) begin
                            state_q <= ST_ADDR;
                            bit_cnt <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (scl_r) begin
                            if (bit_cnt != 3'd7)
                                bit_cnt <= bit_cnt + 3'd1;
                        end else if (bit_cnt == 3'd7) begin
                            state_q <= ST_RW;
                            bit_cnt <= '0;
                        end
                    end
                    ST_RW: begin
                        if (scl_r) begin
                            rw   <= sda_q;
                            full <= 1'b1;
                        end else if (full) begin
                            state_q <= ST_ACK;
                            ack_q   <= ACK_ADDR;
                            full    <= 1'b0;
                        end
                    end
                    ST_ACK: begin
                        if (scl_r) begin
                            full <= 1'b1;
                        end else if (full) begin
                            full    <= 1'b0;
                            bit_cnt <= '0;
                            case (ack_q)
                                ACK_ADDR: begin
                                    if (!addr_match) state_q <= ST_IDLE;
                                    else if (rw)     state_q <= ST_DATA;
                                    else             state_q <= ST_MEM;
                                end
                                ACK_MEM: state_q <= ST_DATA;
                                default: state_q <= ST_IDLE;
                            endcase
                        end
                    end
                    ST_MEM, ST_DATA: begin
                        if (scl_r) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                full <= 1'b1;
                        end else if (full) begin
                            state_q <= ST_ACK;
                            ack_q   <= (state_q == ST_MEM) ? ACK_MEM : ACK_DATA;
                            bit_cnt <= '0;
                            full    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (tmo_c) begin
                timeout <= 1'b1;
                state_q <= ST_IDLE;
                bit_cnt <= '0;
                full    <= 1'b0;
            end
        end
    end

    assign state     = state_q;
    assign ack_phase = ack_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb/tb_i2c_slave_fsm.sv - scoreboard bench for i2c_slave_fsm
module tb_i2c_slave_fsm;

    localparam int H = 6;

    logic clk = 1'b0;
    logic reset, SCL, SDA, addr_match;

    logic [2:0] state, bit_cnt;
    logic       rw, scl_rise, scl_fall, start_det, stop_det, timeout, busy;
    logic [1:0] ack_phase;

    logic [2:0] state0, bit_cnt0;
    logic       rw0, scl_rise0, scl_fall0, start_det0, stop_det0, timeout0, busy0;
    logic [1:0] ack_phase0;

    always #5 clk = ~clk;

    i2c_slave_fsm #(.TIMEOUT(16'd100)) dut (
        .clk(clk), .reset(reset), .SCL(SCL), .SDA(SDA), .addr_match(addr_match),
        .state(state), .bit_cnt(bit_cnt), .rw(rw), .ack_phase(ack_phase),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
        .stop_det(stop_det), .timeout(timeout), .busy(busy)
    );

    i2c_slave_fsm #(.TIMEOUT(16'd0)) dut0 (
        .clk(clk), .reset(reset), .SCL(SCL), .SDA(SDA), .addr_match(addr_match),
        .state(state0), .bit_cnt(bit_cnt0), .rw(rw0), .ack_phase(ack_phase0),
        .scl_rise(scl_rise0), .scl_fall(scl_fall0), .start_det(start_det0),
        .stop_det(stop_det0), .timeout(timeout0), .busy(busy0)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       rw;
        logic [1:0] ack;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] last_state = 3'd0;
    int checks = 0, errors = 0;
    int start_cnt = 0, stop_cnt = 0, tmo_cnt = 0, tmo0_cnt = 0;

    always @(negedge clk) begin
        if (start_det) start_cnt++;
        if (stop_det)  stop_cnt++;
        if (timeout)   tmo_cnt++;
        if (timeout0)  tmo0_cnt++;
        if (reset) begin
            last_state = state;
        end else if (state !== last_state) begin
            last_state = state;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected state=%0d required no change", state);
            end else begin
                mon_e = exp_q.pop_front();
                if (state !== mon_e.st || rw !== mon_e.rw ||
                    (state == 3'd4 && ack_phase !== mon_e.ack)) begin
                    errors++;
                    $display("FAIL monitor_state actual st=%0d rw=%0d ack=%0d required st=%0d rw=%0d ack=%0d",
                             state, rw, ack_phase, mon_e.st, mon_e.rw, mon_e.ack);
                end
            end
        end
    end

    function automatic void push(input logic [2:0] st, input logic r, input logic [1:0] a);
        exp_t e;
        e.st = st; e.rw = r; e.ack = a;
        exp_q.push_back(e);
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; SCL = 1'b1; SDA = 1'b1;
        hold(3);
        reset = 1'b0;
        hold(3);
        exp_q.delete();
    endtask

    task automatic bus_start;
        SDA = 1'b1; hold(H);
        SCL = 1'b1; hold(H);
        SDA = 1'b0; hold(H);
        SCL = 1'b0; hold(H);
    endtask

    task automatic send_bit(input logic b);
        SDA = b;    hold(H);
        SCL = 1'b1; hold(H);
        SCL = 1'b0; hold(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic bus_stop;
        SDA = 1'b0; hold(H);
        SCL = 1'b1; hold(H);
        SDA = 1'b1; hold(H);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        hold(2);
        checks++;
        if ({state, bit_cnt, rw, ack_phase, scl_rise, scl_fall, start_det, stop_det, timeout, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values actual st=%0d bc=%0d rw=%0d ack=%0d busy=%0d required all 0",
                     state, bit_cnt, rw, ack_phase, busy);
        end
        reset = 1'b0;
        hold(3);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0 || scl_rise !== 1'b0 || start_det !== 1'b0) begin
            errors++;
            $display("FAIL reset_release actual st=%0d busy=%0d required 0 0", state, busy);
        end
    endtask

    task automatic write_seq(input logic [7:0] data, input logic with_stop);
        push(1,0,0); push(2,0,0); push(3,0,0); push(4,0,0); push(5,0,0);
        push(4,0,1); push(6,0,1); push(4,0,2); push(0,0,2);
        bus_start;
        send_byte(8'h04); send_bit(1'b0);
        send_byte(8'h10); send_bit(1'b0);
        send_byte(data);  send_bit(1'b0);
        if (with_stop) bus_stop;
    endtask

    task automatic test_write;
        do_reset;
        addr_match = 1'b1;
        write_seq(8'hA5, 1'b1);
        hold(4);
        check_drained("write");
    endtask

    task automatic test_read;
        do_reset;
        addr_match = 1'b1;
        push(1,0,0); push(2,0,0); push(3,0,0); push(4,1,0); push(6,1,0); push(4,1,2); push(0,1,2);
        bus_start;
        send_byte(8'h05); send_bit(1'b0);
        send_byte(8'h5A); send_bit(1'b1);
        bus_stop;
        hold(4);
        check_drained("read");
    endtask

    task automatic test_mismatch;
        do_reset;
        addr_match = 1'b0;
        push(1,0,0); push(2,0,0); push(3,0,0); push(4,0,0); push(0,0,0);
        bus_start;
        send_byte(8'h0A);
        SDA = 1'b1; hold(H);
        SCL = 1'b1; hold(H);
        SCL = 1'b0; hold(2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_busy_early actual=%0d required 1", busy);
        end
        hold(1);
        checks++;
        if (busy !== 1'b0 || scl_fall !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_busy_drop actual busy=%0d fall=%0d required 0 1", busy, scl_fall);
        end
        hold(H);
        send_byte(8'h33);
        bus_stop;
        hold(4);
        check_drained("mismatch");
    endtask

    task automatic test_restart_stop;
        int s0, p0;
        do_reset;
        addr_match = 1'b1;
        push(1,0,0); push(2,0,0); push(3,0,0); push(4,0,0); push(5,0,0);
        push(1,0,0); push(2,0,0); push(3,0,0); push(4,1,0); push(6,1,0); push(0,1,0);
        bus_start;
        send_byte(8'h04); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        checks++;
        if (bit_cnt !== 3'd4 || state !== 3'd5) begin
            errors++;
            $display("FAIL mem_bits actual st=%0d bc=%0d required 5 4", state, bit_cnt);
        end
        s0 = start_cnt;
        SDA = 1'b1; hold(H);
        SCL = 1'b1; hold(H);
        SDA = 1'b0; hold(4);
        checks++;
        if (start_cnt - s0 != 1 || state !== 3'd1 || bit_cnt !== 3'd0 || rw !== 1'b0) begin
            errors++;
            $display("FAIL restart actual pulses=%0d st=%0d bc=%0d rw=%0d required 1 1 0 0",
                     start_cnt - s0, state, bit_cnt, rw);
        end
        SCL = 1'b0; hold(H);
        send_byte(8'h05); send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        SDA = 1'b0; hold(H);
        SCL = 1'b1; hold(H);
        p0 = stop_cnt;
        SDA = 1'b1; hold(2);
        checks++;
        if (state !== 3'd6 || bit_cnt !== 3'd5) begin
            errors++;
            $display("FAIL data_bit5 actual st=%0d bc=%0d required 6 5", state, bit_cnt);
        end
        hold(1);
        checks++;
        if (state !== 3'd0 || stop_det !== 1'b1) begin
            errors++;
            $display("FAIL stop_in_data actual st=%0d stop=%0d required 0 1", state, stop_det);
        end
        hold(3);
        checks++;
        if (stop_cnt - p0 != 1) begin
            errors++;
            $display("FAIL stop_pulse actual=%0d required 1", stop_cnt - p0);
        end
        check_drained("restart");
    endtask

    task automatic test_timeout;
        int k, t0, t1;
        do_reset;
        addr_match = 1'b1;
        push(1,0,0); push(2,0,0); push(3,0,0); push(4,1,0); push(6,1,0); push(0,1,0);
        bus_start;
        send_byte(8'h05); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0);
        SDA = 1'b1; hold(H);
        SCL = 1'b1; hold(H);
        t0 = tmo0_cnt;
        t1 = tmo_cnt;
        SCL = 1'b0;
        k = 0;
        while (!scl_fall && k < 20) begin hold(1); k++; end
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL fall_latency actual=%0d required 3", k);
        end
        k = 0;
        while (!timeout && k < 300) begin hold(1); k++; end
        checks++;
        if (k != 100 || state !== 3'd0) begin
            errors++;
            $display("FAIL timeout_delay actual=%0d st=%0d required 100 0", k, state);
        end
        hold(200);
        checks++;
        if (tmo_cnt - t1 != 1) begin
            errors++;
            $display("FAIL timeout_pulse actual=%0d required 1", tmo_cnt - t1);
        end
        checks++;
        if (tmo0_cnt != t0 || state0 !== 3'd6) begin
            errors++;
            $display("FAIL timeout_disabled actual pulses=%0d st=%0d required 0 6", tmo0_cnt - t0, state0);
        end
        check_drained("timeout");
    endtask

    task automatic test_reset_mid_addr;
        do_reset;
        addr_match = 1'b1;
        push(1,0,0); push(2,0,0);
        bus_start;
        send_bit(1'b0); send_bit(1'b0);
        SDA = 1'b1; hold(H);
        SCL = 1'b1; hold(2);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({state, bit_cnt, rw, ack_phase, scl_rise, scl_fall, start_det, stop_det, timeout, busy} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset actual st=%0d bc=%0d busy=%0d required 0 0 0", state, bit_cnt, busy);
        end
        hold(2);
        reset = 1'b0;
        check_drained("reset_mid");
        SCL = 1'b0; hold(H);
        send_byte(8'hC5);
        send_byte(8'h3A);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_rearm actual st=%0d busy=%0d required 0 0", state, busy);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        addr_match = 1'b1;
        write_seq(8'hA5, 1'b0);
        write_seq(8'h3C, 1'b1);
        hold(4);
        check_drained("back_to_back");
    endtask

    initial begin
        reset = 1'b1; SCL = 1'b1; SDA = 1'b1; addr_match = 1'b0;
        hold(3);
        reset = 1'b0;
        hold(2);
        test_reset;
        test_write;
        test_read;
        test_mismatch;
        test_restart_stop;
        test_timeout;
        test_reset_mid_addr;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired required finish before 2ms");
        $fatal(1, "watchdog");
    end

endmodule
